// File: rtl/tdm_demux.sv
// De-interleaves a TDM sample stream into CHANNELS parallel lanes.
// Frames are gathered in a shadow buffer and published on dout in one registered update.
module tdm_demux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 2,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic                      dout_valid,
    output logic [CH_W-1:0]           sel,
    output logic                      locked,
    output logic                      sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CH_W-1:0] LAST_SEL = CH_W'(CHANNELS - 1);
    localparam logic [CH_W-1:0] ONE_SEL  = CH_W'(1);

    state_t                      r_state, w_state_nxt;
    logic [CH_W-1:0]             r_sel, w_sel_nxt;
    logic [CHANNELS*WIDTH-1:0]   r_shadow, w_shadow_nxt;
    logic [CHANNELS*WIDTH-1:0]   r_dout, w_dout_nxt;
    logic                        r_dout_valid, w_dout_valid_nxt;
    logic                        r_sync_err, w_sync_err_nxt;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_shadow_nxt     = r_shadow;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = 1'b0;
        w_sync_err_nxt   = 1'b0;

        if (din_valid) begin
            unique case (r_state)
                HUNT: begin
                    if (frame_sync) begin
                        w_shadow_nxt[WIDTH-1:0] = din;
                        w_sel_nxt               = ONE_SEL;
                        w_state_nxt             = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        // A sync anywhere but channel 0 abandons the partial frame.
                        w_sync_err_nxt          = (r_sel != '0);
                        w_shadow_nxt[WIDTH-1:0] = din;
                        w_sel_nxt               = ONE_SEL;
                    end else begin
                        w_shadow_nxt[int'(r_sel)*WIDTH +: WIDTH] = din;
                        if (r_sel == LAST_SEL) begin
                            w_dout_nxt       = w_shadow_nxt;
                            w_dout_valid_nxt = 1'b1;
                            w_sel_nxt        = '0;
                        end else begin
                            w_sel_nxt = r_sel + ONE_SEL;
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= HUNT;
            r_sel        <= '0;
            r_shadow     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_sync_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_shadow     <= w_shadow_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_sync_err   <= w_sync_err_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sel        = r_sel;
    assign locked     = (r_state == LOCKED);
    assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: a 1-bit/2-channel and an 8-bit/4-channel instance, both checked
// every cycle against a frame-collecting model, plus literal checks on known streams.
module tb_tdm_demux;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       din_a  = 1'b0, val_a = 1'b0, sync_a = 1'b0;
    logic [7:0] din_b  = 8'h0;
    logic       val_b  = 1'b0, sync_b = 1'b0;

    logic [1:0]  dout_a;
    logic        dv_a, lock_a, err_a;
    logic [0:0]  sel_a;
    logic [31:0] dout_b;
    logic        dv_b, lock_b, err_b;
    logic [1:0]  sel_b;

    tdm_demux #(.WIDTH(1), .CHANNELS(2), .CH_W(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(val_a), .frame_sync(sync_a),
        .dout(dout_a), .dout_valid(dv_a), .sel(sel_a), .locked(lock_a), .sync_err(err_a)
    );

    tdm_demux #(.WIDTH(8), .CHANNELS(4), .CH_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(val_b), .frame_sync(sync_b),
        .dout(dout_b), .dout_valid(dv_b), .sel(sel_b), .locked(lock_b), .sync_err(err_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: a list of samples collected for the current frame, published when full.
    localparam int CH[2] = '{2, 4};
    localparam int WD[2] = '{1, 8};
    int          m_cnt  [2];
    logic [7:0]  m_buf  [2][4];
    bit          m_lock [2];
    logic [31:0] m_dout [2];
    bit          m_dv   [2];
    bit          m_err  [2];

    task automatic m_step(input int i, input logic [7:0] d, input logic v, input logic s);
        m_dv[i]  = 1'b0;
        m_err[i] = 1'b0;
        if (v) begin
            if (s) begin
                m_err[i]    = m_lock[i] && (m_cnt[i] != 0);
                m_lock[i]   = 1'b1;
                m_buf[i][0] = d;
                m_cnt[i]    = 1;
            end else if (m_lock[i]) begin
                m_buf[i][m_cnt[i]] = d;
                m_cnt[i]++;
                if (m_cnt[i] == CH[i]) begin
                    m_dout[i] = '0;
                    for (int k = 0; k < CH[i]; k++)
                        m_dout[i] = m_dout[i] | (32'(m_buf[i][k]) << (k * WD[i]));
                    m_dv[i]  = 1'b1;
                    m_cnt[i] = 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_lock[i] = 1'b0; m_dout[i] = '0; m_dv[i] = 1'b0; m_err[i] = 1'b0;
            end
        end else begin
            cyc++;
            m_step(0, {7'b0, din_a}, val_a, sync_a);
            m_step(1, din_b, val_b, sync_b);
        end
    end

    // Pulse logs feed the literal checks in the stimulus process.
    logic [1:0]  log_a[$];
    logic [31:0] log_b[$];
    int          cyc_a[$];
    int          cyc_b[$];
    int          errcnt_a = 0, errcnt_b = 0;

    always @(negedge clk) begin
        check("a_dout",   64'(dout_a), 64'(m_dout[0][1:0]));
        check("a_valid",  64'(dv_a),   64'(m_dv[0]));
        check("a_err",    64'(err_a),  64'(m_err[0]));
        check("a_locked", 64'(lock_a), 64'(m_lock[0]));
        check("a_sel",    64'(sel_a),  64'(m_cnt[0]));
        check("b_dout",   64'(dout_b), 64'(m_dout[1]));
        check("b_valid",  64'(dv_b),   64'(m_dv[1]));
        check("b_err",    64'(err_b),  64'(m_err[1]));
        check("b_locked", 64'(lock_b), 64'(m_lock[1]));
        check("b_sel",    64'(sel_b),  64'(m_cnt[1]));
        if (dv_a) begin log_a.push_back(dout_a); cyc_a.push_back(cyc); end
        if (dv_b) begin log_b.push_back(dout_b); cyc_b.push_back(cyc); end
        if (err_a) errcnt_a++;
        if (err_b) errcnt_b++;
    end

    task automatic send_a(input logic d, input logic s);
        @(posedge clk); #2;
        din_a = d; val_a = 1'b1; sync_a = s;
    endtask

    task automatic send_b(input logic [7:0] d, input logic s);
        @(posedge clk); #2;
        din_b = d; val_b = 1'b1; sync_b = s;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #2;
            val_a = 1'b0; sync_a = $urandom_range(0, 1); din_a = $urandom_range(0, 1);
            val_b = 1'b0; sync_b = $urandom_range(0, 1); din_b = 8'($urandom);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rst_dout_a", 64'(dout_a), 64'd0);
        check("rst_lock_a", 64'(lock_a), 64'd0);
        check("rst_sel_a",  64'(sel_a),  64'd0);
        check("rst_dout_b", 64'(dout_b), 64'd0);
        check("rst_lock_b", 64'(lock_b), 64'd0);
        check("rst_sel_b",  64'(sel_b),  64'd0);
        check("rst_flags",  64'({dv_a, err_a, dv_b, err_b}), 64'd0);
        val_a = 1'b0; val_b = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int base, eb, t;
        logic [1:0]  f;
        logic [31:0] fr;
        logic [31:0] exp_q[$];

        #12 rst_n = 1'b1;
        idle(2);

        // Two W=1 frames: {ch1,ch0} = 01 then 10.
        base = log_a.size();
        send_a(1'b1, 1'b1); send_a(1'b0, 1'b0); send_a(1'b0, 1'b1); send_a(1'b1, 1'b0);
        idle(3);
        check("t2_pulses", 64'(log_a.size()), 64'(base + 2));
        if (log_a.size() == base + 2) begin
            check("t2_frame0", 64'(log_a[base]),     64'h1);
            check("t2_frame1", 64'(log_a[base + 1]), 64'h2);
        end

        // Reset mid-stream on both instances.
        send_a(1'b1, 1'b1); send_b(8'hA5, 1'b1);
        pulse_reset();

        // Unsynchronised samples are dropped while hunting.
        base = log_a.size();
        repeat (3) send_a(1'b1, 1'b0);
        idle(2);
        check("t3_locked", 64'(lock_a), 64'd0);
        check("t3_pulses", 64'(log_a.size()), 64'(base));
        check("t3_dout",   64'(dout_a), 64'd0);

        // Idle gaps inside a frame do not change the result or the latency.
        base = log_a.size();
        send_a(1'b1, 1'b1); idle(3); send_a(1'b0, 1'b0);
        t = cyc;
        idle(3);
        check("t4_pulses", 64'(log_a.size()), 64'(base + 1));
        if (log_a.size() == base + 1) begin
            check("t4_frame",   64'(log_a[base]), 64'h1);
            check("t4_latency", 64'(cyc_a[base]), 64'(t + 1));
        end

        // Mid-frame resync on the 4-channel instance.
        base = log_b.size(); eb = errcnt_b;
        send_b(8'h11, 1'b1); send_b(8'h22, 1'b0); send_b(8'h33, 1'b1);
        send_b(8'h44, 1'b0); send_b(8'h55, 1'b0); send_b(8'h66, 1'b0);
        idle(2);
        check("t5_errs",   64'(errcnt_b), 64'(eb + 1));
        check("t5_pulses", 64'(log_b.size()), 64'(base + 1));
        if (log_b.size() == base + 1)
            check("t5_frame", 64'(log_b[base]), 64'h66554433);

        // Every 2-bit frame, back to back, with a pulse every 2 cycles.
        base = log_a.size();
        for (int v = 0; v < 4; v++) begin
            f = 2'(v);
            send_a(f[0], 1'b1); send_a(f[1], 1'b0);
        end
        idle(2);
        check("t6a_pulses", 64'(log_a.size()), 64'(base + 4));
        for (int v = 0; v < 4 && base + v < log_a.size(); v++) begin
            check("t6a_frame", 64'(log_a[base + v]), 64'(v));
            if (v > 0) check("t6a_period", 64'(cyc_a[base + v] - cyc_a[base + v - 1]), 64'd2);
        end

        // Random back-to-back 4-channel frames, sometimes relying on the flywheel.
        base = log_b.size();
        for (int n = 0; n < 40; n++) begin
            fr = $urandom;
            exp_q.push_back(fr);
            for (int k = 0; k < 4; k++)
                send_b(fr[8*k +: 8], (k == 0) && ($urandom_range(0, 3) != 0));
        end
        idle(2);
        check("t6b_pulses", 64'(log_b.size()), 64'(base + 40));
        for (int n = 0; n < 40 && base + n < log_b.size(); n++) begin
            check("t6b_frame", 64'(log_b[base + n]), 64'(exp_q[n]));
            if (n > 0) check("t6b_period", 64'(cyc_b[base + n] - cyc_b[base + n - 1]), 64'd4);
        end

        // Free-running random traffic; the per-cycle comparison does the work.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #2;
            val_a  = ($urandom_range(0, 3) != 0);
            sync_a = ($urandom_range(0, 2) == 0);
            din_a  = $urandom_range(0, 1);
            val_b  = ($urandom_range(0, 3) != 0);
            sync_b = ($urandom_range(0, 5) == 0);
            din_b  = 8'($urandom);
            if (n == 700) pulse_reset();
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
